// File: rtl/act_pack.sv
// Post-activation packer: ReLU, rounding right shift and unsigned 8-bit
// saturation per sample, then four bytes packed per 32-bit output word.
module act_pack #(
  parameter int SHIFT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_last
);

  // Half of one output LSB, added before the shift for round-half-up.
  localparam logic [64:0] ROUND = 65'd1 << (SHIFT - 1);

  logic [64:0] relu_w;
  logic [64:0] sum_w;
  logic [64:0] q_w;
  logic [7:0]  byte_w;

  logic [1:0]  idx_q,    idx_d;
  logic [31:0] acc_q,    acc_d;
  logic [3:0]  keep_q,   keep_d;
  logic [31:0] mdata_q,  mdata_d;
  logic [3:0]  mkeep_q,  mkeep_d;
  logic        mlast_q,  mlast_d;
  logic        mvalid_q, mvalid_d;

  logic        in_xfer;
  logic        out_xfer;
  logic [31:0] merged_acc_w;
  logic [3:0]  merged_keep_w;

  // 65-bit arithmetic keeps the rounding add of the largest positive input from wrapping.
  always_comb begin
    relu_w = ($signed(s_data) <= 64'sd0) ? 65'd0 : {1'b0, s_data};
    sum_w  = relu_w + ROUND;
    q_w    = sum_w >> SHIFT;
    byte_w = (q_w > 65'd255) ? 8'hFF : q_w[7:0];
  end

  assign s_ready  = !mvalid_q || m_ready;
  assign in_xfer  = s_valid && s_ready;
  assign out_xfer = mvalid_q && m_ready;

  assign merged_acc_w  = acc_q | ({24'd0, byte_w} << {idx_q, 3'b000});
  assign merged_keep_w = keep_q | (4'b0001 << idx_q);

  always_comb begin
    idx_d    = idx_q;
    acc_d    = acc_q;
    keep_d   = keep_q;
    mdata_d  = mdata_q;
    mkeep_d  = mkeep_q;
    mlast_d  = mlast_q;
    mvalid_d = mvalid_q;

    if (out_xfer) begin
      mvalid_d = 1'b0;
    end

    // A completing sample reloads the output register, overriding the clear above.
    if (in_xfer) begin
      if (idx_q == 2'd3 || s_last) begin
        mdata_d  = merged_acc_w;
        mkeep_d  = merged_keep_w;
        mlast_d  = s_last;
        mvalid_d = 1'b1;
        acc_d    = 32'd0;
        keep_d   = 4'd0;
        idx_d    = 2'd0;
      end else begin
        acc_d  = merged_acc_w;
        keep_d = merged_keep_w;
        idx_d  = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= 2'd0;
      acc_q    <= 32'd0;
      keep_q   <= 4'd0;
      mdata_q  <= 32'd0;
      mkeep_q  <= 4'd0;
      mlast_q  <= 1'b0;
      mvalid_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      keep_q   <= keep_d;
      mdata_q  <= mdata_d;
      mkeep_q  <= mkeep_d;
      mlast_q  <= mlast_d;
      mvalid_q <= mvalid_d;
    end
  end

  assign m_valid = mvalid_q;
  assign m_data  = mdata_q;
  assign m_keep  = mkeep_q;
  assign m_last  = mlast_q;

endmodule

// File: tb/tb_act_pack.sv
// Scoreboard bench for act_pack: stimulus pushes expected words from a
// byte-list reference model, a forked monitor pops and compares them.
module tb_act_pack;

  localparam int SHIFT = 16;
  localparam longint unsigned SCALE = 64'd1 << SHIFT;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;

  int n_tests;
  int n_fails;

  logic   ready_fixed;
  logic   rand_ready;
  word_t  exp_q[$];
  logic [7:0] pend_q[$];

  act_pack #(.SHIFT(SHIFT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_last  (m_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference byte: ReLU, then floor((v + SCALE/2) / SCALE), clamped to 255.
  function automatic logic [7:0] model_byte(input logic [63:0] v);
    logic [64:0] q;
    if ($signed(v) <= 64'sd0) return 8'd0;
    q = ({1'b0, v} + 65'(SCALE / 2)) / 65'(SCALE);
    return (q > 65'd255) ? 8'hFF : q[7:0];
  endfunction

  function automatic void model_accept(input logic [63:0] v, input logic last);
    word_t w;
    pend_q.push_back(model_byte(v));
    if (pend_q.size() == 4 || last) begin
      w.data = 32'd0;
      w.keep = 4'd0;
      w.last = last;
      for (int k = 0; k < pend_q.size(); k++) begin
        w.data[8*k +: 8] = pend_q[k];
        w.keep[k]        = 1'b1;
      end
      exp_q.push_back(w);
      pend_q.delete();
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one sample and holds it until accepted; waited = negedges spent.
  task automatic applyStimulus(input logic [63:0] v, input logic last, output int waited);
    logic acc;
    s_valid = 1'b1;
    s_data  = v;
    s_last  = last;
    waited  = 0;
    acc     = 1'b0;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      waited++;
      acc = s_ready;
      @(posedge clk);
      if (acc) model_accept(v, last);
      #1;
    end
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic monitor();
    logic        prev_hold;
    logic [36:0] prev_word;
    word_t       w;
    prev_hold = 1'b0;
    prev_word = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold)
          checkOutput("hold_stable", {27'd0, m_valid, m_data, m_keep, m_last},
                      {27'd0, 1'b1, prev_word});
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_word", {27'd0, m_data, m_keep, m_last}, 64'd0);
          end else begin
            w = exp_q.pop_front();
            checkOutput("word", {27'd0, m_data, m_keep, m_last},
                        {27'd0, w.data, w.keep, w.last});
          end
        end
        prev_hold = m_valid && !m_ready;
        prev_word = {m_data, m_keep, m_last};
      end
    end
  endtask

  task automatic ready_driver();
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      m_ready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_fixed;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_m_valid"}, {63'd0, m_valid}, 64'd0);
    checkOutput({tag, "_m_data"},  {32'd0, m_data},  64'd0);
    checkOutput({tag, "_m_keep"},  {60'd0, m_keep},  64'd0);
    checkOutput({tag, "_m_last"},  {63'd0, m_last},  64'd0);
    checkOutput({tag, "_s_ready"}, {63'd0, s_ready}, 64'd1);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int          w;
    logic [63:0] r;
    logic [63:0] held;
    n_tests     = 0;
    n_fails     = 0;
    rst_n       = 1'b0;
    s_valid     = 1'b0;
    s_data      = 64'd0;
    s_last      = 1'b0;
    ready_fixed = 1'b1;
    rand_ready  = 1'b0;
    fork
      monitor();
      ready_driver();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Rounding and ReLU
    applyStimulus(64'h18000, 1'b0, w);
    applyStimulus(64'h17FFF, 1'b0, w);
    applyStimulus(-64'sd5,   1'b0, w);
    applyStimulus(64'd0,     1'b1, w);
    checkOutput("round_valid", {63'd0, m_valid}, 64'd1);
    checkOutput("round_data",  {32'd0, m_data},  64'h102);
    checkOutput("round_keep",  {60'd0, m_keep},  64'hF);
    checkOutput("round_last",  {63'd0, m_last},  64'd1);
    repeat (2) @(posedge clk); #1;

    // Saturation
    applyStimulus(64'h7FFFFFFFFFFFFFFF, 1'b0, w);
    applyStimulus(64'h00FF8000,         1'b0, w);
    applyStimulus(64'h00FF7FFF,         1'b0, w);
    applyStimulus(64'h10000,            1'b0, w);
    checkOutput("sat_data", {32'd0, m_data}, 64'h01FFFFFF);
    checkOutput("sat_last", {63'd0, m_last}, 64'd0);

    // Partial flush
    applyStimulus(64'h10000, 1'b0, w);
    applyStimulus(64'h20000, 1'b1, w);
    checkOutput("partial_data", {32'd0, m_data}, 64'h0201);
    checkOutput("partial_keep", {60'd0, m_keep}, 64'h3);
    checkOutput("partial_last", {63'd0, m_last}, 64'd1);

    // Back-to-back, m_valid pulses once per four samples
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(64'(i) << 16, 1'b0, w);
      checkOutput("b2b_valid", {63'd0, m_valid}, {63'd0, (i % 4) == 0});
    end
    wait_drain();

    // Backpressure
    ready_fixed = 1'b0;
    @(posedge clk); #1;
    for (int i = 21; i <= 24; i++) applyStimulus(64'(i) << 16, 1'b0, w);
    s_valid = 1'b1;
    s_data  = 64'(25) << 16;
    held    = {32'd0, m_data};
    checkOutput("bp_word", held, 64'h18171615);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_s_ready", {63'd0, s_ready}, 64'd0);
      checkOutput("bp_m_data",  {32'd0, m_data},  held);
    end
    @(posedge clk); #1;
    ready_fixed = 1'b1;
    applyStimulus(64'(25) << 16, 1'b0, w);
    checkOutput("bp_release_wait", 64'(w), 64'd1);

    // Random run with random downstream readiness
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r = {$urandom, $urandom};
      r = $signed(r) >>> $urandom_range(0, 62);
      applyStimulus(r, $urandom_range(0, 4) == 0, w);
    end
    applyStimulus(64'h30000, 1'b1, w);
    rand_ready  = 1'b0;
    ready_fixed = 1'b1;
    wait_drain();

    // Reset mid-word discards the partial word
    applyStimulus(64'h50000, 1'b0, w);
    applyStimulus(64'h60000, 1'b0, w);
    rst_n = 1'b0;
    pend_q.delete();
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 9; i <= 12; i++) applyStimulus(64'(i) << 16, 1'b0, w);
    checkOutput("after_reset_data", {32'd0, m_data}, 64'h0C0B0A09);
    checkOutput("after_reset_keep", {60'd0, m_keep}, 64'hF);
    wait_drain();
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
